// File: rtl/datapath_pkg.sv
// Shared opcode/funct encodings and the R-type instruction layout for the datapath slice.
package datapath_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

endpackage

// File: rtl/datapath_alu.sv
// R-type ALU: computes the funct-selected result and flags whether funct is supported.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [4:0]   i_shamt,
  input  logic [5:0]   i_funct,
  output logic [W-1:0] o_result,
  output logic         o_valid
);

  // Unsupported functs yield zero and drop o_valid so the top suppresses the write.
  always_comb begin
    o_result = '0;
    o_valid  = 1'b1;
    case (i_funct)
      F_ADD, F_ADDU: o_result = i_a + i_b;
      F_SUB, F_SUBU: o_result = i_a - i_b;
      F_AND:         o_result = i_a & i_b;
      F_OR:          o_result = i_a | i_b;
      F_XOR:         o_result = i_a ^ i_b;
      F_NOR:         o_result = ~(i_a | i_b);
      F_SLT:         o_result = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      F_SLTU:        o_result = {{(W-1){1'b0}}, (i_a < i_b)};
      F_SLL:         o_result = i_b << i_shamt;
      F_SRL:         o_result = i_b >> i_shamt;
      F_SRA:         o_result = $signed(i_b) >>> i_shamt;
      default:       o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_im.sv
// Word-addressed instruction ROM with combinational read; contents are loaded hierarchically.
module datapath_im #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_instr
);

  logic [31:0] imem [0:DEPTH-1];

  assign o_instr = imem[i_addr];

endmodule

// File: rtl/datapath_rf.sv
// 32-entry register file: two async read ports, one clocked write port, $0 hardwired to zero.
module datapath_rf
  import datapath_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clock,
  input  logic         i_we,
  input  logic [4:0]   i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [4:0]   i_raddr1,
  input  logic [4:0]   i_raddr2,
  output logic [W-1:0] o_rdata1,
  output logic [W-1:0] o_rdata2
);

  logic [W-1:0] regArray [0:31];

  // No reset: contents survive Reset so benches can preload and inspect them.
  always_ff @(posedge clock) begin
    if (i_we && (i_waddr != 5'd0)) begin
      regArray[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : regArray[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : regArray[i_raddr2];

endmodule

// File: rtl/datapath.sv
// Single-cycle R-type datapath: fetch at PC, execute on the ALU, write rd, advance PC by 4.
module datapath #(
  parameter int DATA_W     = datapath_pkg::DATA_W,
  parameter int IMEM_DEPTH = 64
) (
  input  logic              clock,
  input  logic              Reset,
  output logic [DATA_W-1:0] Dout
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0]         r_pc;
  logic [31:0]         w_instrWord;
  datapath_pkg::instr_t w_instr;
  logic [DATA_W-1:0]   w_rsData;
  logic [DATA_W-1:0]   w_rtData;
  logic [DATA_W-1:0]   w_aluResult;
  logic                w_aluValid;
  logic                w_isRtype;
  logic                w_we;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 32'd4;
    end
  end

  datapath_im #(.DEPTH(IMEM_DEPTH), .AW(AW)) im (
    .i_addr  (r_pc[AW+1:2]),
    .o_instr (w_instrWord)
  );

  assign w_instr   = datapath_pkg::instr_t'(w_instrWord);
  assign w_isRtype = (w_instr.op == datapath_pkg::OP_RTYPE);

  // Gating the write with Reset keeps any edge seen while Reset is low from committing.
  assign w_we = Reset && w_isRtype && w_aluValid;

  datapath_rf #(.W(DATA_W)) rf (
    .clock    (clock),
    .i_we     (w_we),
    .i_waddr  (w_instr.rd),
    .i_wdata  (w_aluResult),
    .i_raddr1 (w_instr.rs),
    .i_raddr2 (w_instr.rt),
    .o_rdata1 (w_rsData),
    .o_rdata2 (w_rtData)
  );

  datapath_alu #(.W(DATA_W)) alu (
    .i_a      (w_rsData),
    .i_b      (w_rtData),
    .i_shamt  (w_instr.shamt),
    .i_funct  (w_instr.funct),
    .o_result (w_aluResult),
    .o_valid  (w_aluValid)
  );

  assign Dout = w_isRtype ? w_aluResult : '0;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed lab program, mid-run reset, PC wrap, then random programs vs a model.
module tb_datapath;

  logic        clock;
  logic        Reset;
  logic [31:0] Dout;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] modelRegs [32];
  logic [31:0] modelImem [64];
  logic [31:0] modelPc;

  logic [5:0]  functList [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  logic [31:0] dirDout [6]    = '{32'h8, 32'h2, 32'h1, 32'h50, 32'h8, 32'h0};

  datapath #(.DATA_W(32), .IMEM_DEPTH(64)) dut (
    .clock (clock),
    .Reset (Reset),
    .Dout  (Dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference semantics of one instruction against the model register state.
  function automatic void refExec(input logic [31:0] instr, output logic [31:0] res, output logic we);
    logic [31:0] a;
    logic [31:0] b;
    int          sh;
    a   = modelRegs[instr[25:21]];
    b   = modelRegs[instr[20:16]];
    sh  = int'(instr[10:6]);
    res = 32'h0;
    we  = 1'b0;
    if (instr[31:26] == 6'h00) begin
      we = 1'b1;
      case (instr[5:0])
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24:        res = a & b;
        6'h25:        res = a | b;
        6'h26:        res = a ^ b;
        6'h27:        res = ~(a | b);
        6'h2A:        res = (int'(a) < int'(b)) ? 32'h1 : 32'h0;
        6'h2B:        res = (a < b) ? 32'h1 : 32'h0;
        6'h00:        res = b << sh;
        6'h02:        res = b >> sh;
        6'h03:        res = int'(b) >>> sh;
        default:      we  = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [31:0] randInstr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8)
      return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              functList[$urandom_range(0, 12)]};
    else if (sel == 8)
      return {6'h00, 26'($urandom)};
    else
      return $urandom;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkDout(input string tag);
    logic [31:0] res;
    logic        we;
    refExec(modelImem[modelPc[7:2]], res, we);
    checkOutput(tag, Dout, res);
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s_r%0d", tag, i), dut.rf.regArray[i], modelRegs[i]);
  endtask

  // Advance one rising edge, updating the model as the hardware should, and return at the negedge.
  task automatic clockEdge();
    logic [31:0] res;
    logic        we;
    @(posedge clock);
    if (Reset) begin
      refExec(modelImem[modelPc[7:2]], res, we);
      if (we && (modelImem[modelPc[7:2]][15:11] != 5'd0))
        modelRegs[modelImem[modelPc[7:2]][15:11]] = res;
      modelPc = modelPc + 32'd4;
    end
    @(negedge clock);
  endtask

  task automatic applyStimulus(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      checkDout($sformatf("%s_dout%0d", tag, k));
      clockEdge();
    end
  endtask

  task automatic loadReg(input int idx, input logic [31:0] val);
    modelRegs[idx]          = (idx == 0) ? 32'h0 : val;
    dut.rf.regArray[idx]    = modelRegs[idx];
  endtask

  task automatic loadWord(input int idx, input logic [31:0] word);
    modelImem[idx]   = word;
    dut.im.imem[idx] = word;
  endtask

  initial begin
    Reset   = 1'b0;
    modelPc = 32'h0;
    for (int i = 0; i < 32; i++) loadReg(i, 32'h0);
    loadReg(1, 32'h5);
    loadReg(2, 32'h3);
    for (int i = 0; i < 64; i++) loadWord(i, 32'h0);
    loadWord(0, 32'h00221820);
    loadWord(1, 32'h00222022);
    loadWord(2, 32'h0041282A);
    loadWord(3, 32'h00013100);
    loadWord(4, 32'h00220020);
    loadWord(5, 32'h8C010000);

    // Initial reset cycle: an edge passes with Reset low and must not write.
    @(negedge clock);
    checkOutput("rst_dout", Dout, 32'h8);
    checkOutput("rst_pc", dut.r_pc, 32'h0);
    checkOutput("rst_noWrite_r3", dut.rf.regArray[3], 32'h0);
    #2 Reset = 1'b1;
    #1;

    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("dir_const_dout%0d", k), Dout, dirDout[k]);
      checkDout($sformatf("dir_model_dout%0d", k));
      clockEdge();
    end
    checkOutput("dir_r3", dut.rf.regArray[3], 32'h8);
    checkOutput("dir_r4", dut.rf.regArray[4], 32'h2);
    checkOutput("dir_r5", dut.rf.regArray[5], 32'h1);
    checkOutput("dir_r6", dut.rf.regArray[6], 32'h50);
    checkOutput("dir_r0", dut.rf.regArray[0], 32'h0);
    checkRegs("dirDump");

    // Mid-run asynchronous reset between edges.
    applyStimulus(3, "nop");
    #2 Reset = 1'b0;
    #1;
    modelPc = 32'h0;
    checkOutput("midrst_pc", dut.r_pc, 32'h0);
    checkOutput("midrst_dout", Dout, 32'h8);
    loadReg(3, 32'h0);
    clockEdge();
    checkOutput("midrst_noWrite_r3", dut.rf.regArray[3], 32'h0);
    checkOutput("midrst_hold_pc", dut.r_pc, 32'h0);
    #2 Reset = 1'b1;
    #1;
    applyStimulus(1, "rerun");
    checkOutput("rerun_r3", dut.rf.regArray[3], 32'h8);

    // 63 more edges bring PC to 256, which fetches word 0 again.
    applyStimulus(63, "wrap");
    checkOutput("wrap_pc", dut.r_pc, 32'd256);
    checkOutput("wrap_dout", Dout, 32'h8);
    checkRegs("finalDump");

    // Random programs and register contents against the reference model.
    for (int round = 0; round < 3; round++) begin
      #2 Reset = 1'b0;
      for (int i = 1; i < 32; i++) loadReg(i, $urandom);
      loadReg(7, 32'h80000000);
      loadReg(8, 32'h7FFFFFFF);
      for (int i = 0; i < 64; i++) loadWord(i, randInstr());
      modelPc = 32'h0;
      #1;
      checkDout($sformatf("rand%0d_rst", round));
      Reset = 1'b1;
      #1;
      applyStimulus(150, $sformatf("rand%0d", round));
      checkRegs($sformatf("rand%0dDump", round));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle, R-type-only MIPS-style datapath: PC, word-addressed instruction memory, 32x32 register file and ALU.
- Each clock executes the instruction at PC, writes the ALU result to rd, and advances PC by 4.
- Dout exposes the current ALU result for observation.
- Top-level compute block used for register-transfer labs; the register file and instruction memory are preloaded by the bench through hierarchy.

Parameters:
- DATA_W, 32, datapath/register width
- IMEM_DEPTH, 64, instruction memory words (power of two)

Ports:
- clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Dout  out  DATA_W  current-cycle ALU result (combinational)

Behaviour:
- Required hierarchy, so benches can preload and dump state:
  - register file instance "rf", storage array "regArray[0:31]" of DATA_W bits
  - instruction memory instance "im", storage array "imem[0:IMEM_DEPTH-1]" of 32 bits
- PC (32-bit):
  - Reset low clears PC to 0 immediately, asynchronously.
  - Otherwise PC <= PC+4 on each rising clock.
  - imem index = PC[log2(IMEM_DEPTH)+1:2], so fetch wraps to word 0 after the last word.
- Instruction fetch: combinational read of imem.
- Decode fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- Register file:
  - Two combinational read ports (rs, rt) and one synchronous write port (rd) on the rising clock.
  - Reading register 0 always returns 0; writes to register 0 are discarded.
  - Not cleared by reset; contents persist through reset.
  - Read-during-write returns the old value; the new value is visible the next cycle.
- Write enable asserted only when all hold:
  - Reset high
  - op==6'h00
  - funct is supported
- ALU, selected by funct (A=rs value, B=rt value):
  - 20 add, 21 addu: A+B, modulo 2^32, no overflow trap
  - 22 sub, 23 subu: A-B
  - 24 and, 25 or, 26 xor, 27 nor
  - 2A slt: signed A<B ? 1 : 0
  - 2B sltu: unsigned compare, same result form
  - 00 sll: B<<shamt
  - 02 srl: B>>shamt, logical
  - 03 sra: B>>>shamt, arithmetic
- Unsupported funct or op!=0: ALU result 0 and no register write.
- Dout = ALU result; combinational, changes within the cycle after PC/imem/regfile settle.
- Reset asserted mid-run:
  - PC=0 at once and Dout reflects imem[0].
  - No register write occurs on any edge while Reset is low.
  - Execution restarts at imem[0] on the first edge after release.
- Memory contents at power-up are undefined unless preloaded; no internal initialisation file.

Decomposition:
- Shared package:
  - opcode constant OP_RTYPE
  - funct constants (F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA)
  - DATA_W
- rf and im are mandatory instances.
- One further natural sub-module: alu (operands A, B, shamt, funct -> result, valid).

Test Plan (preload rf[1]=5, rf[2]=3, all others 0; Reset low for one cycle, then high):
- imem[0]=00221820 (add $3,$1,$2) -> Dout=00000008 during cycle 0; rf[3]=00000008 after the edge.
- imem[1]=00222022 (sub $4,$1,$2) -> Dout=00000002; rf[4]=2. imem[2]=0041282A (slt $5,$2,$1) -> Dout=1; rf[5]=1.
- imem[3]=00013100 (sll $6,$1,4) -> Dout=00000050; rf[6]=50.
- imem[4]=00220020 (add $0,$1,$2) -> Dout=8; rf[0] remains 0. imem[5]=8C010000 (non-R-type) -> Dout=0; no register changes.
- Reset behaviour:
  - During the initial Reset-low cycle no write occurs, so rf[3] is still 0 at the first edge.
  - Drive Reset low mid-run asynchronously between edges -> PC=0 and Dout shows imem[0]'s result immediately.
  - After release, re-executing imem[0] rewrites rf[3]=8.
- Run 64+ cycles -> PC wraps and fetch returns to imem[0].
- Final dump of rf[0..31] matches the expected values above.
